// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Each slot has a blank interval followed by the lit digit; display data is double-buffered.
module seg7_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int PRESCALE_W   = 32,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] period_i,
  input  logic [31:0]           data_i,
  input  logic [7:0]            dp_i,
  input  logic [7:0]            en_mask_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic [7:0]            an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_start_o
);

  localparam int DIGIT_W = $clog2(N_DIGITS);
  localparam logic [PRESCALE_W-1:0] MIN_EFF    = PRESCALE_W'(BLANK_CYCLES + 1);
  localparam logic [PRESCALE_W-1:0] BLANK_LAST = PRESCALE_W'(BLANK_CYCLES - 1);
  localparam logic [DIGIT_W-1:0]    LAST_DIGIT = DIGIT_W'(N_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t                state_reg, state_next;
  logic [PRESCALE_W-1:0] cnt_reg, cnt_next;
  logic [PRESCALE_W-1:0] on_last_reg, on_last_next;
  logic [DIGIT_W-1:0]    digit_reg, digit_next;
  logic                  started_reg, started_next;
  logic [7:0]            an_reg, an_next;
  logic [6:0]            seg_reg, seg_next;
  logic                  dp_reg, dp_next;
  logic                  fs_reg, fs_next;
  logic                  boundary;

  logic [31:0]           active_data_reg, pending_data_reg;
  logic [7:0]            active_dp_reg, pending_dp_reg;
  logic                  pending_reg;

  logic [PRESCALE_W-1:0] eff_period;
  logic [6:0]            seg_all [N_DIGITS];
  logic [7:0]            an_all  [N_DIGITS];
  logic                  lit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign seg_all[gi] = hex_to_seg(active_data_reg[gi*4 +: 4]);
      assign an_all[gi]  = ~(8'(1) << gi);
    end
  endgenerate

  // ON lasts at least one cycle, so short periods are clamped up
  assign eff_period = (period_i < MIN_EFF) ? MIN_EFF : period_i;
  assign lit        = en_mask_i[digit_reg];

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    on_last_next = on_last_reg;
    digit_next   = digit_reg;
    started_next = started_reg;
    an_next      = an_reg;
    seg_next     = seg_reg;
    dp_next      = dp_reg;
    fs_next      = 1'b0;
    boundary     = 1'b0;
    if (!started_reg) begin
      // first edge after reset release opens digit 0's blank as a new frame
      started_next = 1'b1;
      state_next   = ST_BLANK;
      cnt_next     = '0;
      digit_next   = '0;
      on_last_next = eff_period - MIN_EFF;
      fs_next      = 1'b1;
      an_next      = 8'hFF;
      seg_next     = 7'h7F;
      dp_next      = 1'b1;
    end else begin
      case (state_reg)
        ST_BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next = ST_ON;
            cnt_next   = '0;
            an_next    = lit ? an_all[digit_reg] : 8'hFF;
            seg_next   = lit ? seg_all[digit_reg] : 7'h7F;
            dp_next    = lit ? ~active_dp_reg[digit_reg] : 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          if (cnt_reg == on_last_reg) begin
            state_next   = ST_BLANK;
            cnt_next     = '0;
            digit_next   = (digit_reg == LAST_DIGIT) ? '0 : digit_reg + 1'b1;
            on_last_next = eff_period - MIN_EFF;
            boundary     = (digit_reg == LAST_DIGIT);
            fs_next      = (digit_reg == LAST_DIGIT);
            an_next      = 8'hFF;
            seg_next     = 7'h7F;
            dp_next      = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_BLANK;
      cnt_reg     <= '0;
      on_last_reg <= '0;
      digit_reg   <= '0;
      started_reg <= 1'b0;
      an_reg      <= 8'hFF;
      seg_reg     <= 7'h7F;
      dp_reg      <= 1'b1;
      fs_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      on_last_reg <= on_last_next;
      digit_reg   <= digit_next;
      started_reg <= started_next;
      an_reg      <= an_next;
      seg_reg     <= seg_next;
      dp_reg      <= dp_next;
      fs_reg      <= fs_next;
    end
  end

  // A capture never coincides with a promotion: ready is low whenever pending is set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_data_reg  <= '0;
      active_dp_reg    <= '0;
      pending_data_reg <= '0;
      pending_dp_reg   <= '0;
      pending_reg      <= 1'b0;
    end else if (boundary && pending_reg) begin
      active_data_reg <= pending_data_reg;
      active_dp_reg   <= pending_dp_reg;
      pending_reg     <= 1'b0;
    end else if (data_valid_i && !pending_reg) begin
      pending_data_reg <= data_i;
      pending_dp_reg   <= dp_i;
      pending_reg      <= 1'b1;
    end
  end

  assign data_ready_o  = ~pending_reg;
  assign an_o          = an_reg;
  assign seg_o         = seg_reg;
  assign dp_o          = dp_reg;
  assign frame_start_o = fs_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: slot-position reference model checked every cycle,
// table-driven frame vectors, and directed reset / boundary-handshake sequences.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] period_i = 32'd20;
  logic [31:0] data_i = '0;
  logic [7:0]  dp_i = '0;
  logic [7:0]  en_mask_i = 8'hFF;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_start_o;

  int checks = 0;
  int failures = 0;

  seg7_scan_ctrl dut (
    .clk(clk), .rst(rst), .period_i(period_i), .data_i(data_i), .dp_i(dp_i),
    .en_mask_i(en_mask_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o), .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: position within slot, not state encoding
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  bit          m_started = 0;
  longint      m_pos = 0, m_len = 5;
  int          m_digit = 0;
  logic [7:0]  m_mask = 0;
  logic [31:0] m_act = 0, m_pend_d = 0;
  logic [7:0]  m_act_dp = 0, m_pend_dp = 0;
  bit          m_pend = 0, m_fs = 0, m_bnd, m_ready_now;

  function automatic longint eff(input logic [31:0] p);
    return (p < 5) ? 64'd5 : longint'(p);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_started = 0; m_pos = 0; m_digit = 0; m_pend = 0; m_fs = 0;
      m_act = 0; m_act_dp = 0; m_mask = 0;
    end else begin
      m_ready_now = !m_pend;
      m_bnd = 0;
      if (!m_started) begin
        m_started = 1; m_pos = 0; m_digit = 0; m_len = eff(period_i); m_fs = 1;
      end else begin
        m_pos++;
        m_fs = 0;
        if (m_pos == m_len) begin
          m_bnd = (m_digit == 7);
          m_digit = (m_digit + 1) % 8;
          m_pos = 0;
          m_len = eff(period_i);
          m_fs = (m_digit == 0);
        end
      end
      if (m_pos == 4) m_mask = en_mask_i;
      if (m_bnd && m_pend) begin
        m_act = m_pend_d; m_act_dp = m_pend_dp; m_pend = 0;
      end
      if (data_valid_i && m_ready_now) begin
        m_pend_d = data_i; m_pend_dp = dp_i; m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, on_lit;
    logic [3:0] nib;
    on_lit = m_started && (m_pos >= 4) && m_mask[m_digit];
    nib    = m_act[m_digit*4 +: 4];
    e_an   = on_lit ? ~(8'd1 << m_digit) : 8'hFF;
    e_seg  = on_lit ? hex_tab[nib] : 7'h7F;
    e_dp   = on_lit ? ~m_act_dp[m_digit] : 1'b1;
    chk("model_an", an_o, e_an);
    chk("model_seg", seg_o, e_seg);
    chk("model_dp", dp_o, e_dp);
    chk("model_fs", frame_start_o, m_fs);
    chk("model_ready", data_ready_o, !m_pend);
  end

  // ---------------- helpers
  task automatic wait_fs(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_start_o && n < 3000);
    if (!frame_start_o) begin checks++; failures++; $display("FAIL %s_timeout: no frame_start", name); end
  endtask

  task automatic offer(input logic [31:0] d, input logic [7:0] dp);
    int n = 0;
    while (!data_ready_o && n < 3000) begin @(negedge clk); n++; end
    if (!data_ready_o) begin checks++; failures++; $display("FAIL offer_timeout: ready stuck low"); end
    data_i = d; dp_i = dp; data_valid_i = 1;
    @(negedge clk);
    data_valid_i = 0;
  endtask

  typedef struct {
    logic [31:0] period, data;
    logic [7:0]  dp, mask;
    int          frame;
    logic [7:0]  an0, an7;
    logic [6:0]  seg0, seg7;
    logic        dp0, dp7;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32'd20, 32'h01234567, 8'h00, 8'hFF, 160, 8'hFE, 8'h7F, 7'h78, 7'h40, 1'b1, 1'b1};
    vecs[1] = '{32'd20, 32'hDEADBEEF, 8'h81, 8'hFF, 160, 8'hFE, 8'h7F, 7'h0E, 7'h21, 1'b0, 1'b0};
    vecs[2] = '{32'd20, 32'h89ABCDEF, 8'h80, 8'h0F, 160, 8'hFE, 8'hFF, 7'h0E, 7'h7F, 1'b1, 1'b1};
    vecs[3] = '{32'd0,  32'hFEDCBA98, 8'h01, 8'hFF, 40,  8'hFE, 8'h7F, 7'h00, 7'h0E, 1'b0, 1'b1};
    vecs[4] = '{32'd7,  32'h5A000003, 8'h00, 8'h81, 56,  8'hFE, 8'h7F, 7'h30, 7'h12, 1'b1, 1'b1};
    vecs[5] = '{32'd5,  32'hC00000B0, 8'h00, 8'hFF, 40,  8'hFE, 8'h7F, 7'h40, 7'h46, 1'b1, 1'b1};

    #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("reset_an", an_o, 8'hFF);
    chk("reset_seg", seg_o, 7'h7F);
    chk("reset_ready", data_ready_o, 1'b1);
    chk("reset_fs", frame_start_o, 1'b0);
    rst = 1;
    @(negedge clk);
    chk("first_fs", frame_start_o, 1'b1);

    // table-driven frame vectors
    for (int v = 0; v < 6; v++) begin
      int c, e;
      logic [7:0] a0, a7;
      logic [6:0] s0, s7;
      logic d0, d7;
      period_i = vecs[v].period;
      en_mask_i = vecs[v].mask;
      offer(vecs[v].data, vecs[v].dp);
      wait_fs("vec_load");
      e = vecs[v].frame / 8;
      c = 0; a0 = 0; a7 = 0; s0 = 0; s7 = 0; d0 = 0; d7 = 0;
      do begin
        if (c == 4) begin a0 = an_o; s0 = seg_o; d0 = dp_o; end
        if (c == 7*e + 4) begin a7 = an_o; s7 = seg_o; d7 = dp_o; end
        @(negedge clk); c++;
      end while (!frame_start_o && c < 3000);
      $display("vec %0d: period=%0d data=%08h frame=%0d d0 an=%02h seg=%02h d7 an=%02h seg=%02h",
               v, vecs[v].period, vecs[v].data, c, a0, s0, a7, s7);
      chk("vec_frame_len", c, vecs[v].frame);
      chk("vec_an0", a0, vecs[v].an0);
      chk("vec_seg0", s0, vecs[v].seg0);
      chk("vec_dp0", d0, vecs[v].dp0);
      chk("vec_an7", a7, vecs[v].an7);
      chk("vec_seg7", s7, vecs[v].seg7);
      chk("vec_dp7", d7, vecs[v].dp7);
    end

    // asynchronous reset mid-ON discards pending data
    offer(32'h13572468, 8'hFF);
    begin
      int n = 0;
      while (an_o == 8'hFF && n < 3000) begin @(negedge clk); n++; end
    end
    #2 rst = 0;
    #1;
    chk("async_an", an_o, 8'hFF);
    chk("async_seg", seg_o, 7'h7F);
    chk("async_dp", dp_o, 1'b1);
    chk("async_ready", data_ready_o, 1'b1);
    chk("async_fs", frame_start_o, 1'b0);
    $display("async reset: an=%02h seg=%02h ready=%0b", an_o, seg_o, data_ready_o);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("release_fs", frame_start_o, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 3) period_i = $urandom_range(0, 12);
      if ($urandom_range(0, 99) < 5) en_mask_i = 8'($urandom);
      data_valid_i = ($urandom_range(0, 99) < 20);
      data_i = $urandom;
      dp_i = 8'($urandom);
    end
    data_valid_i = 0;

    // capture on the same edge as the frame boundary: one-frame latency
    period_i = 5;
    en_mask_i = 8'hFF;
    wait_fs("t6_settle");
    wait_fs("t6_settle2");
    begin
      int n = 0;
      while (!(m_started && m_digit == 7 && m_pos == m_len - 1 && data_ready_o) && n < 3000) begin
        @(negedge clk); n++;
      end
      data_i = 32'h76543210; dp_i = 8'h00; data_valid_i = 1;
      @(negedge clk);
      data_valid_i = 0;
      chk("t6_fs_same_edge", frame_start_o, 1'b1);
      chk("t6_ready_low", data_ready_o, 1'b0);
      n = 1;
      while (!data_ready_o && n < 3000) begin @(negedge clk); if (!data_ready_o) n++; end
      $display("boundary capture: ready low for %0d cycles", n);
      chk("t6_ready_low_cycles", n, 40);
      repeat (4) @(negedge clk);
      chk("t6_new_seg0", seg_o, 7'h40);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
